ser_xmt_arb: RTL and testbench

Round-robin arbiter and sequencer sharing one serial-line transmitter among NREQ byte producers (console, debug monitor, boot loader, etc.).
- Accepts bytes over per-requester valid/ready handshakes.
- Drives the transmitter's sr_load/parallel_in and tracks its sr_empty status, so exactly one byte is in flight at a time.
- Sits between the requesters and the transmitter in the serial subsystem. Clocked by the same clk and reset by the same rst as the transmitter.

---
 rtl/ser_xmt_arb.sv | 125 ++++++++++++
 tb/tb_ser_xmt_arb.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ser_xmt_arb.sv
// Round-robin arbiter feeding one serial transmitter, one byte in flight at a time.
// Optional clear-to-send gating is compiled in with `define XMT_CTS_EN.
module ser_xmt_arb #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic               clk,
    input  logic               rst,
`ifdef XMT_CTS_EN
    input  logic               cts,
`endif
    input  logic [NREQ-1:0]    req_valid,
    input  logic [8*NREQ-1:0]  req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               sr_load,
    output logic [7:0]         parallel_in,
    input  logic               sr_empty,
    output logic               busy,
    output logic [PW-1:0]      last_src,
    output logic [15:0]        tx_cnt
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LOAD      = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [1:0]        state;
    logic [PW-1:0]     ptr;
    logic              cts_s;
    logic              found;
    logic [PW-1:0]     g;
    logic [PW:0]       g_sum;
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [8*NREQ-1:0] data_sh;
    logic              xfer;

`ifdef XMT_CTS_EN
    logic cts_m;

    always_ff @(posedge clk) begin
        if (rst) begin
            cts_m <= 1'b0;
            cts_s <= 1'b0;
        end else begin
            cts_m <= cts;
            cts_s <= cts_m;
        end
    end
`else
    assign cts_s = 1'b1;
`endif

    // Rotate valid so bit 0 is the requester at ptr, then take the first set bit.
    always_comb begin
        dbl   = {req_valid, req_valid} >> ptr;
        rot   = dbl[NREQ-1:0];
        found = 1'b0;
        g_sum = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                g_sum = {1'b0, ptr} + (PW+1)'(k);
                if (g_sum >= (PW+1)'(NREQ))
                    g_sum = g_sum - (PW+1)'(NREQ);
            end
        end
        g = g_sum[PW-1:0];
    end

    // Handshake: req_ready is one-hot and only offered in IDLE with the transmitter
    // empty; a byte moves on any cycle where req_valid[i] & req_ready[i].
    always_comb begin
        req_ready = '0;
        if (!rst && state == IDLE && sr_empty && cts_s && found)
            req_ready = NREQ'(1) << g;
    end

    assign xfer    = |(req_valid & req_ready);
    assign data_sh = req_data >> {g, 3'b000};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sr_load     <= 1'b0;
            parallel_in <= 8'h00;
            busy        <= 1'b0;
            last_src    <= '0;
            tx_cnt      <= 16'd0;
            ptr         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        parallel_in <= data_sh[7:0];
                        sr_load     <= 1'b1;
                        busy        <= 1'b1;
                        last_src    <= g;
                        tx_cnt      <= tx_cnt + 16'd1;
                        ptr         <= (g == PW'(NREQ-1)) ? '0 : g + PW'(1);
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    sr_load <= 1'b0;
                    state   <= WAIT_BUSY;
                end
                // sr_empty may still read 1 here; never reload until it has dropped.
                WAIT_BUSY: begin
                    if (!sr_empty)
                        state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (sr_empty) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ser_xmt_arb.sv
// Bench for ser_xmt_arb: transmitter model, transaction-level reference model,
// directed scenarios followed by randomized traffic.
module tb_ser_xmt_arb;

    localparam int NREQ = 4;
    localparam int PW   = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              sr_load;
    logic [7:0]        parallel_in;
    logic              sr_empty;
    logic              busy;
    logic [PW-1:0]     last_src;
    logic [15:0]       tx_cnt;
    logic              xmt_hold = 1'b0;
`ifdef XMT_CTS_EN
    logic              cts = 1'b1;
`endif

    always #5 clk = ~clk;

    ser_xmt_arb #(.NREQ(NREQ), .PW(PW)) dut (
        .clk(clk),
        .rst(rst),
`ifdef XMT_CTS_EN
        .cts(cts),
`endif
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .sr_load(sr_load),
        .parallel_in(parallel_in),
        .sr_empty(sr_empty),
        .busy(busy),
        .last_src(last_src),
        .tx_cnt(tx_cnt)
    );

    // Transmitter: captures the byte on sr_load, then stays busy for a random time.
    int         tx_left = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] rx_log[$];

    always @(posedge clk) begin
        if (rst) tx_left <= 0;
        else if (sr_load) begin
            got_q.push_back(parallel_in);
            tx_left <= $urandom_range(1, 5);
        end else if (tx_left != 0) tx_left <= tx_left - 1;
    end
    assign sr_empty = (tx_left == 0) && !xmt_hold;

    // Reference model state, transaction level.
    int          cyc = 0;
    int          m_acc = -10;
    bit          m_busy = 0;
    bit          m_low = 0;
    int          m_ptr = 0;
    logic [15:0] m_cnt = 0;
    int          m_last = 0;
    logic [7:0]  m_pi = 0;
    bit          m_c1 = 0, m_c2 = 0;
    bit          auto_drop = 1;
    int          n_acc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    function automatic int pick(logic [NREQ-1:0] v, int p);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (p + k) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [NREQ-1:0] er;
        int              g;
        bit              xfer;
        bit              cts_ok;
        logic [7:0]      b;
        @(negedge clk);
`ifdef XMT_CTS_EN
        cts_ok = m_c2;
`else
        cts_ok = 1'b1;
`endif
        g  = pick(req_valid, m_ptr);
        er = '0;
        if (!rst && !m_busy && sr_empty && cts_ok && g >= 0) er[g] = 1'b1;
        xfer = (er != '0);
        chk("req_ready", req_ready, er);
        chk("sr_load", sr_load, (m_busy && cyc == m_acc + 1));
        chk("parallel_in", parallel_in, m_pi);
        chk("busy", busy, m_busy);
        chk("last_src", last_src, m_last);
        chk("tx_cnt", tx_cnt, m_cnt);
        while (got_q.size() > 0) begin
            b = got_q.pop_front();
            rx_log.push_back(b);
            chk("sb_pending", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("tx_byte", b, exp_q.pop_front());
        end
        if (rst) begin
            m_busy = 0; m_low = 0; m_acc = -10; m_ptr = 0;
            m_cnt = 0; m_last = 0; m_pi = 0;
            exp_q.delete();
        end else begin
            if (m_busy && cyc >= m_acc + 2) begin
                if (!m_low) begin
                    if (!sr_empty) m_low = 1;
                end else if (sr_empty) begin
                    m_busy = 0;
                    m_low  = 0;
                end
            end
            if (xfer) begin
                m_busy = 1; m_low = 0; m_acc = cyc;
                m_pi   = req_data[8*g +: 8];
                m_last = g;
                m_cnt  = m_cnt + 16'd1;
                m_ptr  = (g + 1) % NREQ;
                exp_q.push_back(m_pi);
                n_acc++;
            end
        end
`ifdef XMT_CTS_EN
        if (rst) begin
            m_c1 = 0; m_c2 = 0;
        end else begin
            m_c2 = m_c1; m_c1 = cts;
        end
`endif
        @(posedge clk);
        #1;
        cyc++;
        if (xfer && auto_drop) req_valid[g] = 1'b0;
    endtask

    task automatic wait_acc(input int n, input int budget, output int used);
        int target;
        target = n_acc + n;
        used = 0;
        while (n_acc < target && used < budget) begin
            step();
            used++;
        end
        chk("acc_timeout", (n_acc >= target), 1);
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((m_busy || exp_q.size() > 0) && c < 60) begin
            step();
            c++;
        end
        chk("drain_timeout", m_busy, 0);
        step();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int used;
        int base;
        int c;
        repeat (2) @(posedge clk);
        #1;
        // Reset values, ready held low under rst even with requests pending.
        req_valid = 4'hF;
        step();
        rst = 1'b0;
        req_valid = '0;
        step();

        // Single byte from requester 0.
        req_data[7:0] = 8'h41;
        req_valid = 4'b0001;
        auto_drop = 1;
        wait_acc(1, 5, used);
        chk("t1_latency", used, 1);
        drain();
        chk("t1_byte", rx_log[rx_log.size()-1], 8'h41);
        chk("t1_cnt", tx_cnt, 16'd1);
        chk("t1_last", last_src, 0);

        // Round robin with every requester continuously valid.
        reset_dut();
        for (int i = 0; i < NREQ; i++) req_data[8*i +: 8] = 8'h30 + 8'(i);
        base = rx_log.size();
        auto_drop = 0;
        req_valid = 4'hF;
        wait_acc(8, 200, used);
        req_valid = '0;
        drain();
        for (int k = 0; k < 8; k++)
            chk("t2_order", rx_log[base+k], 8'h30 + 8'(k % 4));

        // Pointer at 2 with requesters 0 and 1 valid: 0 goes first, then 1.
        reset_dut();
        auto_drop = 1;
        req_valid = 4'b0010;
        wait_acc(1, 10, used);
        drain();
        base = rx_log.size();
        auto_drop = 0;
        req_valid = 4'b0011;
        wait_acc(2, 100, used);
        req_valid = '0;
        drain();
        chk("t3_first", rx_log[base], 8'h30);
        chk("t3_second", rx_log[base+1], 8'h31);

        // Stall while busy; data changed before acceptance is what gets sent.
        auto_drop = 1;
        req_data[7:0] = 8'h11;
        req_valid = 4'b0001;
        step();
        req_data[23:16] = 8'h55;
        req_valid[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_stall_ready", req_ready, 4'b0000);
        end
        req_data[23:16] = 8'hAA;
        wait_acc(1, 50, used);
        drain();
        chk("t4_new_data", rx_log[rx_log.size()-1], 8'hAA);

        // Reset while waiting for the transmitter to finish.
        req_data[15:8] = 8'h66;
        req_valid = 4'b0010;
        wait_acc(1, 10, used);
        c = 0;
        while (!m_low && c < 20) begin
            step();
            c++;
        end
        chk("t5_busy_before_rst", busy, 1);
        reset_dut();
        chk("t5_busy", busy, 0);
        chk("t5_sr_load", sr_load, 0);
        chk("t5_cnt", tx_cnt, 16'd0);
        req_data[15:8]  = 8'h77;
        req_data[31:24] = 8'h99;
        req_valid = 4'b1010;
        wait_acc(1, 10, used);
        req_valid = '0;
        drain();
        chk("t5_lowest", rx_log[rx_log.size()-1], 8'h77);

        // Transmitter not empty while idle: nothing is accepted.
        xmt_hold = 1'b1;
        req_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t6_hold_ready", req_ready, 4'b0000);
        end
        xmt_hold = 1'b0;
        wait_acc(1, 10, used);
        drain();

`ifdef XMT_CTS_EN
        // Clear-to-send gating and completion of an accepted byte.
        cts = 1'b0;
        req_data[7:0] = 8'hC3;
        req_valid = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("cts_block", req_ready, 4'b0000);
        end
        cts = 1'b1;
        wait_acc(1, 10, used);
        chk("cts_latency", used, 3);
        req_valid = 4'b0010;
        step();
        cts = 1'b0;
        drain();
        chk("cts_complete", rx_log[rx_log.size()-1], 8'hC3);
        for (int k = 0; k < 3; k++) step();
        chk("cts_held_ready", req_ready, 4'b0000);
        cts = 1'b1;
        wait_acc(1, 10, used);
        req_valid = '0;
        drain();
`endif

        // Randomized traffic.
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 3) == 0) req_valid = NREQ'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) req_data = $urandom;
            if ($urandom_range(0, 49) == 0) auto_drop = !auto_drop;
            xmt_hold = ($urandom_range(0, 7) == 0);
`ifdef XMT_CTS_EN
            if ($urandom_range(0, 9) == 0) cts = !cts;
`endif
            step();
        end
        req_valid = '0;
        xmt_hold = 1'b0;
        drain();
        chk("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
